dwell_driver: RTL and testbench
===============================

// Module: dwell_driver
// PURPOSE
//  Output-side counterpart of the button debouncer: drives one external line (LED, relay, enable pin)
//  from single-cycle set/clear event strobes, and guarantees the pin never transitions twice within
//  MIN_DWELL clocks. Events arriving during a dwell are latched (last wins) and applied when it expires.
//  It is fed by press/release strobes or CPU-style control pulses, and feeds a top-level output pin.
// PARAMETERS
//  MIN_DWELL  500000  min clocks between successive o_state transitions; legal 1..2**CNT_W
//  CNT_W      19      dwell counter width
//  INIT       1'b0    o_state / target level after reset
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  i_set      in   1      request level 1 (single-cycle strobe, may be held)
//  i_clr      in   1      request level 0 (single-cycle strobe, may be held)
//  o_state    out  1      registered line level, drives the pin
//  o_rise     out  1      1-cycle strobe: o_state went 0->1 this cycle
//  o_fall     out  1      1-cycle strobe: o_state went 1->0 this cycle
//  o_ready    out  1      1 = dwell expired, a request this cycle is applied at the next edge
//  o_pending  out  1      1 = latched target differs from o_state (waiting on dwell)
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides all inputs): o_state=INIT, target=INIT, cnt=0, o_rise=o_fall=0.
//   After reset: o_ready=1, o_pending=0.
//  Request decode: req = i_set&~i_clr -> 1; i_clr&~i_set -> 0; neither or both -> no request (target kept).
//  target <= req when a request is present. Applies in every cycle, ready or not.
//  o_ready = (cnt==0). o_pending = (target != o_state), computed from registers only.
//  Effective level eff = req if a request is present, else target.
//  READY (cnt==0) and eff != o_state at an edge:
//   - o_state <= eff.
//   - o_rise/o_fall <= 1 for exactly the first cycle o_state shows the new level.
//   - cnt <= MIN_DWELL-1.
//   - Latency is 1 clock: a request in cycle t gives a new o_state in cycle t+1.
//  READY and eff == o_state: nothing changes; strobes 0.
//  HOLD (cnt!=0): cnt decrements by 1 per cycle and o_state is frozen. Requests only update target.
//  When cnt reaches 0, the next edge applies target if it differs from o_state (READY rule).
//  Spacing between two o_state transitions is >= MIN_DWELL cycles, and exactly MIN_DWELL for a
//   request that is pending or arrives on the cycle cnt==0.
//  A request that reverts within one dwell (set then clr while o_state=0) cancels: target==o_state,
//   so no transition and no strobe occur.
//  MIN_DWELL=1: cnt always loads 0, so o_state may toggle every cycle.
//  cnt never wraps: it loads at most 2**CNT_W-1 and stops at 0.
//  o_rise and o_fall are never both 1; each is 0 in every cycle without a transition.
//  All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
// TESTING (MIN_DWELL=4, INIT=0)
//  1 Reset: rst high 2 cycles, then low -> o_state=0, o_ready=1, o_pending=0, o_rise=o_fall=0.
//  2 i_set at cycle 10 -> o_state=1 from cycle 11; o_rise=1 in cycle 11 only;
//     o_ready=0 in cycles 11-13, o_ready=1 in cycle 14.
//  3 i_set@10, i_clr@12 -> o_pending=1 in cycles 13-14; o_state=0 at cycle 15 with o_fall=1 in cycle 15
//     (rise 11, fall 15: spacing 4).
//  4 i_set@10, i_clr@12, i_set@13 -> o_pending=1 in cycle 13 only; o_state stays 1; no o_fall.
//  5 i_set and i_clr together at cycle 20 while READY, o_state=0 -> no change; o_pending stays 0.
//  6 i_set@10, rst@12 with i_clr also high@12 -> cycle 13: o_state=0, o_ready=1, o_pending=0, no strobes.
//     Then i_set@13 -> o_state=1 at cycle 14.

Source files
------------

// File: rtl/dwell_driver.sv
// Output line driver: applies set/clear strobes to a pin, spacing
// successive pin transitions at least MIN_DWELL clocks apart.
module dwell_driver #(
  parameter int         MIN_DWELL = 500000,
  parameter int         CNT_W     = 19,
  parameter logic       INIT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_set,
  input  logic i_clr,
  output logic o_state,
  output logic o_rise,
  output logic o_fall,
  output logic o_ready,
  output logic o_pending
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MIN_DWELL - 1);

  logic             r_state;
  logic             r_target;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;

  logic             w_req_vld;
  logic             w_req;
  logic             w_eff;
  logic             w_ready;
  logic             w_fire;
  logic             w_state_nxt;
  logic             w_target_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Set and clear together cancel each other out.
  assign w_req_vld = i_set ^ i_clr;
  assign w_req     = i_set;
  assign w_eff     = w_req_vld ? w_req : r_target;
  assign w_ready   = (r_cnt == '0);
  assign w_fire    = w_ready && (w_eff != r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= INIT;
      r_target <= INIT;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    if (w_req_vld)
      w_target_nxt = w_req;
    if (w_fire) begin
      w_state_nxt = w_eff;
      w_rise_nxt  = w_eff;
      w_fall_nxt  = ~w_eff;
      w_cnt_nxt   = LOAD;
    end else if (!w_ready) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    o_state   = r_state;
    o_rise    = r_rise;
    o_fall    = r_fall;
    o_ready   = w_ready;
    o_pending = (r_target != r_state);
  end

endmodule

// File: tb/tb_dwell_driver.sv
// Bench for dwell_driver: vector table at MIN_DWELL=4 plus a
// short MIN_DWELL=1 sequence, checked through an expectation queue.
module tb_dwell_driver;

  logic clk = 1'b0;
  logic rst, i_set, i_clr;
  logic st4, ri4, fa4, rd4, pe4;
  logic st1, ri1, fa1, rd1, pe1;

  always #5 clk = ~clk;

  dwell_driver #(.MIN_DWELL(4), .CNT_W(3), .INIT(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .i_set(i_set), .i_clr(i_clr),
    .o_state(st4), .o_rise(ri4), .o_fall(fa4),
    .o_ready(rd4), .o_pending(pe4)
  );

  dwell_driver #(.MIN_DWELL(1), .CNT_W(1), .INIT(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .i_set(i_set), .i_clr(i_clr),
    .o_state(st1), .o_rise(ri1), .o_fall(fa1),
    .o_ready(rd1), .o_pending(pe1)
  );

  // exp = {state, rise, fall, ready, pending} seen after the edge
  typedef struct packed {
    logic       rst;
    logic       set;
    logic       clr;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    bit         sel1;
    logic [4:0] exp;
    string      name;
    int         idx;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(logic r, logic s, logic c,
                             logic [4:0] e);
    vec_t x;
    x.rst = r; x.set = s; x.clr = c; x.exp = e;
    return x;
  endfunction

  task automatic step(bit sel1, vec_t x, string name, int idx);
    sb_t e;
    logic [4:0] got;
    rst   = x.rst;
    i_set = x.set;
    i_clr = x.clr;
    e.sel1 = sel1; e.exp = x.exp; e.name = name; e.idx = idx;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    got = e.sel1 ? {st1, ri1, fa1, rd1, pe1}
                 : {st4, ri4, fa4, rd4, pe4};
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("FAIL %s[%0d] got st/ri/fa/rdy/pend=%b want=%b",
               e.name, e.idx, got, e.exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_set = 1'b0; i_clr = 1'b0;
    // reset, 2 cycles
    vecs.push_back(v(1, 0, 0, 5'b00010));
    vecs.push_back(v(1, 0, 0, 5'b00010));
    vecs.push_back(v(0, 0, 0, 5'b00010));
    // single set: rise, ready low 3 cycles
    vecs.push_back(v(0, 1, 0, 5'b11000));
    vecs.push_back(v(0, 0, 0, 5'b10000));
    vecs.push_back(v(0, 0, 0, 5'b10000));
    vecs.push_back(v(0, 0, 0, 5'b10010));
    vecs.push_back(v(0, 0, 0, 5'b10010));
    // clear back down
    vecs.push_back(v(0, 0, 1, 5'b00100));
    vecs.push_back(v(0, 0, 0, 5'b00000));
    vecs.push_back(v(0, 0, 0, 5'b00000));
    vecs.push_back(v(0, 0, 0, 5'b00010));
    // set then clr during dwell: deferred fall, spacing 4
    vecs.push_back(v(0, 1, 0, 5'b11000));
    vecs.push_back(v(0, 0, 0, 5'b10000));
    vecs.push_back(v(0, 0, 1, 5'b10001));
    vecs.push_back(v(0, 0, 0, 5'b10011));
    vecs.push_back(v(0, 0, 0, 5'b00100));
    vecs.push_back(v(0, 0, 0, 5'b00000));
    vecs.push_back(v(0, 0, 0, 5'b00000));
    vecs.push_back(v(0, 0, 0, 5'b00010));
    // set, clr, set: reverted request cancels
    vecs.push_back(v(0, 1, 0, 5'b11000));
    vecs.push_back(v(0, 0, 0, 5'b10000));
    vecs.push_back(v(0, 0, 1, 5'b10001));
    vecs.push_back(v(0, 1, 0, 5'b10010));
    vecs.push_back(v(0, 0, 0, 5'b10010));
    // held set while already high: nothing happens
    vecs.push_back(v(0, 1, 0, 5'b10010));
    vecs.push_back(v(0, 1, 0, 5'b10010));
    vecs.push_back(v(0, 0, 1, 5'b00100));
    vecs.push_back(v(0, 0, 0, 5'b00000));
    vecs.push_back(v(0, 0, 0, 5'b00000));
    vecs.push_back(v(0, 0, 0, 5'b00010));
    // set and clr together while ready
    vecs.push_back(v(0, 1, 1, 5'b00010));
    vecs.push_back(v(0, 0, 0, 5'b00010));
    // reset wins over a clear during dwell
    vecs.push_back(v(0, 1, 0, 5'b11000));
    vecs.push_back(v(0, 0, 0, 5'b10000));
    vecs.push_back(v(1, 0, 1, 5'b00010));
    vecs.push_back(v(0, 1, 0, 5'b11000));
    // clr arrives exactly on the cnt==0 cycle
    vecs.push_back(v(0, 0, 0, 5'b10000));
    vecs.push_back(v(0, 0, 0, 5'b10000));
    vecs.push_back(v(0, 0, 0, 5'b10010));
    vecs.push_back(v(0, 0, 1, 5'b00100));
    vecs.push_back(v(0, 0, 0, 5'b00000));

    for (int i = 0; i < vecs.size(); i++)
      step(1'b0, vecs[i], "dwell4", i);

    // MIN_DWELL=1: toggles every cycle, always ready
    step(1'b1, v(1, 0, 0, 5'b00010), "dwell1", 0);
    step(1'b1, v(0, 1, 0, 5'b11010), "dwell1", 1);
    step(1'b1, v(0, 0, 1, 5'b00110), "dwell1", 2);
    step(1'b1, v(0, 1, 0, 5'b11010), "dwell1", 3);
    step(1'b1, v(0, 0, 0, 5'b10010), "dwell1", 4);
    step(1'b1, v(0, 1, 1, 5'b10010), "dwell1", 5);
    step(1'b1, v(0, 0, 1, 5'b00110), "dwell1", 6);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
